// File: rtl/chroma_subsampler_if.sv
// AXI4-Stream style channel used for both the sample input and sample output of the
// chroma subsampler. The master drives data/valid/last and the slave drives ready.
interface chroma_subsampler_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/chroma_subsampler.sv
// Streaming chroma subsampler: Y/Cb/Cr planar MCU in, Y passed through, Cb/Cr decimated
// to 4:4:4, 4:2:2 or 4:2:0 using a half-row line buffer. Single registered output stage.
// Optional build macro: CHROMA_ROUND_EN enables round-half-up averaging (default truncates).
module chroma_subsampler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MCU_W      = 16,
  parameter int unsigned MCU_H      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [1:0]                  mode,
  chroma_subsampler_if.slave          s_axis,
  chroma_subsampler_if.master         m_axis,
  output logic                        mcu_done,
  output logic                        err_tlast
);

  localparam int unsigned ColW = $clog2(MCU_W);
  localparam int unsigned RowW = $clog2(MCU_H);
  localparam int unsigned LbW  = ColW - 1;
  localparam int unsigned SumW = DATA_WIDTH + 2;
  localparam logic [ColW-1:0] ColLast = ColW'(MCU_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(MCU_H - 1);
`ifdef CHROMA_ROUND_EN
  localparam logic [SumW-1:0] RndPair = SumW'(1);
  localparam logic [SumW-1:0] RndQuad = SumW'(2);
`else
  localparam logic [SumW-1:0] RndPair = '0;
  localparam logic [SumW-1:0] RndQuad = '0;
`endif

  typedef enum logic [1:0] {PhY, PhCb, PhCr} phase_e;

  phase_e                phase_q, phase_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Entries hold a horizontal pair sum from an even row, consumed on the following odd row.
  logic [DATA_WIDTH:0]   line_buf [MCU_W/2];
  logic                  lb_we;
  logic [LbW-1:0]        lb_idx;

  logic                  accept;
  logic                  first_beat;
  logic                  last_beat;
  logic [SumW-1:0]       sum_pair;
  logic [DATA_WIDTH-1:0] avg2;
  logic [DATA_WIDTH-1:0] avg4;

  assign s_axis.tready = !out_valid_q || m_axis.tready;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign first_beat    = (phase_q == PhY) && (col_q == '0) && (row_q == '0);
  assign last_beat     = (phase_q == PhCr) && (col_q == ColLast) && (row_q == RowLast);
  assign lb_idx        = col_q[ColW-1:1];

  assign sum_pair = SumW'(pair_q) + SumW'(s_axis.tdata);
  assign avg2     = DATA_WIDTH'((sum_pair + RndPair) >> 1);
  assign avg4     = DATA_WIDTH'((SumW'(line_buf[lb_idx]) + sum_pair + RndQuad) >> 2);

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign mcu_done      = done_q;
  assign err_tlast     = err_q;

  // Framing counters, decimation datapath and output-stage next state.
  always_comb begin
    phase_d     = phase_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    pair_d      = pair_q;
    lb_we       = 1'b0;
    // Output slot empties when consumed; refilled below if this beat emits.
    out_valid_d = out_valid_q && !m_axis.tready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = out_valid_q && m_axis.tready && out_last_q;
    err_d       = accept && (s_axis.tlast != last_beat);

    if (accept) begin
      if (first_beat) begin
        mode_d = mode;
      end

      if (col_q == ColLast) begin
        col_d = '0;
        if (row_q == RowLast) begin
          row_d = '0;
          unique case (phase_q)
            PhY:     phase_d = PhCb;
            PhCb:    phase_d = PhCr;
            default: phase_d = PhY;
          endcase
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end

      if (phase_q == PhY || mode_q == 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = s_axis.tdata;
        out_last_d  = last_beat;
      end else if (!col_q[0]) begin
        pair_d = s_axis.tdata;
      end else if (!mode_q[1]) begin
        out_valid_d = 1'b1;
        out_data_d  = avg2;
        out_last_d  = last_beat;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = avg4;
        out_last_d  = last_beat;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q     <= PhY;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 2'd0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Line buffer write; no reset since every entry is written before it is read.
  always_ff @(posedge aclk) begin
    if (lb_we) begin
      line_buf[lb_idx] <= sum_pair[DATA_WIDTH:0];
    end
  end

endmodule

// File: tb/tb_chroma_subsampler.sv
// Scoreboard bench for chroma_subsampler: stimulus pushes plane-level reference results,
// a monitor pops and compares every accepted output beat.
module tb_chroma_subsampler;
  localparam int DW = 8;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int N  = W * H;
`ifdef CHROMA_ROUND_EN
  localparam int R1 = 1;
  localparam int R2 = 2;
  localparam int EXP_QUAD = 2;
  localparam int EXP_PAIR = 12;
`else
  localparam int R1 = 0;
  localparam int R2 = 0;
  localparam int EXP_QUAD = 1;
  localparam int EXP_PAIR = 11;
`endif

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] mode    = 2'd0;
  logic       mcu_done;
  logic       err_tlast;

  chroma_subsampler_if #(.DATA_WIDTH(DW)) s_axis ();
  chroma_subsampler_if #(.DATA_WIDTH(DW)) m_axis ();

  chroma_subsampler #(
    .DATA_WIDTH(DW),
    .MCU_W     (W),
    .MCU_H     (H)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .mode     (mode),
    .s_axis   (s_axis),
    .m_axis   (m_axis),
    .mcu_done (mcu_done),
    .err_tlast(err_tlast)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int y [N];
  int cb[N];
  int cr[N];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] obs [0:8191];
  int  out_cnt  = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  bit  rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int pix(input int p, input int i);
    return (p == 0) ? cb[i] : cr[i];
  endfunction

  // Plane-level reference: average whole 1x2 / 2x2 neighbourhoods of the stored planes.
  task automatic push_model(input int md);
    logic [DW:0] q[$];
    logic [DW:0] e;
    for (int i = 0; i < N; i++) q.push_back({1'b0, DW'(y[i])});
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (md == 0) begin
            q.push_back({1'b0, DW'(pix(p, r*W+c))});
          end else if (md == 1) begin
            if (c % 2 == 1)
              q.push_back({1'b0, DW'((pix(p, r*W+c-1) + pix(p, r*W+c) + R1) / 2)});
          end else if (r % 2 == 1 && c % 2 == 1) begin
            q.push_back({1'b0, DW'((pix(p, (r-1)*W+c-1) + pix(p, (r-1)*W+c) +
                                    pix(p, r*W+c-1) + pix(p, r*W+c) + R2) / 4)});
          end
        end
      end
    end
    e = q.pop_back();
    e[DW] = 1'b1;
    q.push_back(e);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic send_beat(input int data, input bit last);
    bit hs;
    bit ok;
    s_axis.tdata  = DW'(data);
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge aclk);
      hs = s_axis.tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: actual=no_ready required=ready");
    end
  endtask

  function automatic int beat_data(input int i);
    if (i < N) return y[i];
    if (i < 2*N) return cb[i-N];
    return cr[i-2*N];
  endfunction

  // Sends one MCU; the mode input is flipped after the first beat to prove it is latched.
  task automatic run_mcu(input int md, input int early, input int stop_at);
    mode = 2'(md);
    for (int i = 0; i < 3*N; i++) begin
      if (stop_at >= 0 && i == stop_at) break;
      send_beat(beat_data(i), (i == 3*N-1) ^ (i == early));
      if (i == 0) mode = (md == 0) ? 2'd2 : 2'd0;
    end
  endtask

  task automatic drain();
    int k;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && k < 5000) begin
      @(negedge aclk);
      k++;
    end
    check("drain_timeout", (k < 5000) ? 0 : 1, 0);
    check("exp_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge aclk);
    check({tag, "_tvalid"},   int'(m_axis.tvalid), 0);
    check({tag, "_tdata"},    int'(m_axis.tdata), 0);
    check({tag, "_tlast"},    int'(m_axis.tlast), 0);
    check({tag, "_mcu_done"}, int'(mcu_done), 0);
    check({tag, "_err_tlast"}, int'(err_tlast), 0);
    check({tag, "_tready"},   int'(s_axis.tready), 1);
  endtask

  // Output-ready driver.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop/compare, stall stability, pulse counting.
  initial begin
    logic [DW:0] e;
    logic [DW:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_hold", int'({m_axis.tlast, m_axis.tdata}), int'(held));
        if (m_axis.tvalid && m_axis.tready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_beat: actual=%0d required=none", m_axis.tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", int'({m_axis.tlast, m_axis.tdata}), int'(e));
          end
          if (out_cnt < 8192) obs[out_cnt] = m_axis.tdata;
          out_cnt++;
        end
        stalled = m_axis.tvalid && !m_axis.tready;
        held = {m_axis.tlast, m_axis.tdata};
        if (mcu_done) done_cnt++;
        if (err_tlast) err_cnt++;
      end
    end
  end

  initial begin
    int base, dbase, ebase;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    check_reset_values("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Mode 0, ramps: 768 beats identical to input.
    for (int i = 0; i < N; i++) begin y[i] = i; cb[i] = i; cr[i] = i; end
    base = out_cnt; dbase = done_cnt; ebase = err_cnt;
    push_model(0); run_mcu(0, -1, -1); drain();
    check("m0_out_count", out_cnt - base, 768);
    check("m0_last_beat_data", int'(obs[base+767]), 255);
    check("m0_mcu_done", done_cnt - dbase, 1);
    check("m0_err_tlast", err_cnt - ebase, 0);

    // Mode 2, Cb=100, Cr=200.
    for (int i = 0; i < N; i++) begin cb[i] = 100; cr[i] = 200; end
    base = out_cnt; dbase = done_cnt;
    push_model(2); run_mcu(2, -1, -1); drain();
    check("m2_out_count", out_cnt - base, 384);
    check("m2_cb_value", int'(obs[base+256]), 100);
    check("m2_cr_value", int'(obs[base+320]), 200);
    check("m2_mcu_done", done_cnt - dbase, 1);

    // Mode 2 rounding: 1,2 / 2,2 block; Cr all 255.
    for (int i = 0; i < N; i++) begin cb[i] = 2; cr[i] = 255; end
    cb[0] = 1;
    base = out_cnt;
    push_model(2); run_mcu(2, -1, -1); drain();
    check("m2_round_quad", int'(obs[base+256]), EXP_QUAD);
    check("m2_no_overflow", int'(obs[base+320]), 255);

    // Mode 1, pairs (10,13).
    for (int i = 0; i < N; i++) begin cb[i] = (i % 2 == 0) ? 10 : 13; cr[i] = i; end
    base = out_cnt;
    push_model(1); run_mcu(1, -1, -1); drain();
    check("m1_out_count", out_cnt - base, 512);
    check("m1_round_pair", int'(obs[base+256]), EXP_PAIR);

    // Random backpressure, back-to-back mode 2 then mode 0.
    for (int i = 0; i < N; i++) begin
      y[i] = $urandom_range(0, 255); cb[i] = $urandom_range(0, 255);
      cr[i] = $urandom_range(0, 255);
    end
    base = out_cnt; dbase = done_cnt; ebase = err_cnt;
    rand_ready = 1'b1;
    push_model(2); run_mcu(2, -1, -1);
    push_model(0); run_mcu(0, -1, -1);
    drain();
    rand_ready = 1'b0;
    check("b2b_out_count", out_cnt - base, 384 + 768);
    check("b2b_mcu_done", done_cnt - dbase, 2);
    check("b2b_err_tlast", err_cnt - ebase, 0);

    // Early tlast at beat 100.
    for (int i = 0; i < N; i++) begin y[i] = i; cb[i] = 255 - i; cr[i] = i; end
    base = out_cnt; ebase = err_cnt;
    push_model(0); run_mcu(0, 100, -1); drain();
    check("early_tlast_err", err_cnt - ebase, 1);
    check("early_tlast_out_count", out_cnt - base, 768);

    // Reset after 400 beats of a mode 0 MCU.
    dbase = done_cnt;
    for (int i = 0; i < 400; i++) exp_q.push_back({1'b0, DW'(beat_data(i))});
    run_mcu(0, -1, 400); drain();
    check("partial_no_done", done_cnt - dbase, 0);
    aresetn = 1'b0;
    check_reset_values("midreset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Fresh MCU after reset, mode 2 on ramps.
    base = out_cnt; dbase = done_cnt; ebase = err_cnt;
    push_model(2); run_mcu(2, -1, -1); drain();
    check("post_reset_out_count", out_cnt - base, 384);
    check("post_reset_mcu_done", done_cnt - dbase, 1);
    check("post_reset_err_tlast", err_cnt - ebase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
